// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and default sizes for the sample-FIFO write arbiter.
package fifo_arb_pkg;

  localparam int DEF_LENGTH = 68;
  localparam int DEF_N_CH   = 4;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CLEAR
  } arb_state_e;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer/FIFO-side signal bundle of the write arbiter; slave is the arbiter's view.
interface fifo_write_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int LENGTH = DEF_LENGTH,
  parameter int N_CH   = DEF_N_CH,
  parameter int CNT_W  = DEF_CNT_W
);

  logic                     enable;
  logic                     clear_req;
  logic [N_CH-1:0]          ch_valid;
  logic [N_CH*LENGTH-1:0]   ch_data;
  logic [N_CH-1:0]          ch_ready;
  logic [LENGTH-1:0]        fifo_i_data;
  logic                     fifo_write;
  logic                     fifo_clear;
  logic                     fifo_full;
  logic                     fifo_full_error;
  logic [N_CH-1:0]          overflow;
  logic [CNT_W-1:0]         drop_cnt;
  logic                     full_err;
  logic                     busy;

  modport master (
    output enable, clear_req, ch_valid, ch_data, fifo_full, fifo_full_error,
    input  ch_ready, fifo_i_data, fifo_write, fifo_clear, overflow, drop_cnt,
           full_err, busy
  );

  modport slave (
    input  enable, clear_req, ch_valid, ch_data, fifo_full, fifo_full_error,
    output ch_ready, fifo_i_data, fifo_write, fifo_clear, overflow, drop_cnt,
           full_err, busy
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_grant.sv
// Round-robin pick: first pending channel at or above rr_ptr_i, wrapping.
module fifo_rr_grant #(
  parameter  int N_CH  = 4,
  localparam int PTR_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  pending_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic [N_CH-1:0]  grant_o,
  output logic [PTR_W-1:0] grant_idx_o,
  output logic             any_o
);

  int idx;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves a latch.
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    idx         = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!any_o && pending_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Funnels N_CH one-entry channel slots into the single FIFO writer port,
// sequencing enable/drain/clear and keeping drop statistics.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int LENGTH = DEF_LENGTH,
  parameter int N_CH   = DEF_N_CH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic                 clk,
  input logic                 reset_n,
  fifo_write_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(N_CH);

  arb_state_e        state_q;
  logic [N_CH-1:0]   pending_q, pending_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N_CH-1:0]   overflow_q;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              full_err_q;
  logic [LENGTH-1:0] slot_q [N_CH];

  logic [N_CH-1:0]   ready, grant_oh, drop_mask;
  logic [PTR_W-1:0]  grant_idx;
  logic              any_pending, go;
  logic [CNT_W:0]    drop_sum;

  fifo_rr_grant #(.N_CH(N_CH)) u_grant (
    .pending_i   (pending_q),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant_oh),
    .grant_idx_o (grant_idx),
    .any_o       (any_pending)
  );

  always_comb begin
    ready     = (state_q == S_RUN) ? ~pending_q : '0;
    go        = ((state_q == S_RUN) || (state_q == S_DRAIN)) && any_pending && !bus.fifo_full;
    drop_mask = (state_q == S_RUN) ? (bus.ch_valid & pending_q) : '0;

    pending_d = pending_q | (bus.ch_valid & ready);
    if (go) pending_d = pending_d & ~grant_oh;

    rr_ptr_d = rr_ptr_q;
    if (go) rr_ptr_d = (grant_idx == PTR_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;

    // Wide sum so the carry out tells us the counter would wrap.
    drop_sum = {1'b0, drop_cnt_q};
    for (int c = 0; c < N_CH; c++) drop_sum = drop_sum + (CNT_W + 1)'(drop_mask[c]);
    drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      state_q    <= S_IDLE;
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      overflow_q <= '0;
      drop_cnt_q <= '0;
      full_err_q <= 1'b0;
    end else if (state_q == S_CLEAR) begin
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      overflow_q <= '0;
      drop_cnt_q <= '0;
      full_err_q <= 1'b0;
      state_q    <= bus.clear_req ? S_CLEAR : (bus.enable ? S_RUN : S_IDLE);
    end else begin
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_q | drop_mask;
      drop_cnt_q <= drop_cnt_d;
      full_err_q <= full_err_q | bus.fifo_full_error;
      if (bus.clear_req) begin
        state_q <= S_CLEAR;
      end else begin
        case (state_q)
          S_IDLE:  if (bus.enable)        state_q <= S_RUN;
          S_RUN:   if (!bus.enable)       state_q <= S_DRAIN;
          S_DRAIN: if (pending_q == '0)   state_q <= S_IDLE;
          default:                        state_q <= S_IDLE;
        endcase
      end
    end
  end

  // NOTE: slot payloads are qualified by pending_q, so they need no reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (bus.ch_valid[c] && ready[c]) slot_q[c] <= bus.ch_data[c*LENGTH +: LENGTH];
    end
  end

  assign bus.ch_ready    = ready;
  assign bus.fifo_write  = go;
  assign bus.fifo_i_data = go ? slot_q[grant_idx] : '0;
  assign bus.fifo_clear  = (state_q == S_CLEAR);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.overflow    = overflow_q;
  assign bus.drop_cnt    = drop_cnt_q;
  assign bus.full_err    = full_err_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized and directed bench for fifo_write_arbiter against a queue-based model.
module tb_fifo_write_arbiter;
  import fifo_arb_pkg::*;

  localparam int LENGTH = 68;
  localparam int N_CH   = 4;
  localparam int CNT_W  = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_CLEAR = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.LENGTH(LENGTH), .N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  fifo_write_arbiter #(.LENGTH(LENGTH), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests, n_fail;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each channel holds a queue of at most one sample.
  int                m_mode;
  logic [LENGTH-1:0] m_slot [N_CH][$];
  int                m_ptr;
  logic [N_CH-1:0]   m_ovf;
  int                m_drops;
  logic              m_ferr;

  logic [N_CH-1:0]   e_ready;
  logic              e_go;
  int                e_grant;
  logic [LENGTH-1:0] e_data;

  logic              obs_write, obs_clear, obs_busy, obs_ferr;
  logic [LENGTH-1:0] obs_data;
  logic [N_CH-1:0]   obs_ready, obs_ovf;
  logic [CNT_W-1:0]  obs_drop;

  task automatic m_reset();
    for (int c = 0; c < N_CH; c++) m_slot[c].delete();
    m_mode = M_IDLE; m_ptr = 0; m_ovf = '0; m_drops = 0; m_ferr = 1'b0;
  endtask

  task automatic m_eval();
    logic anyp;
    anyp = 1'b0;
    e_grant = 0;
    for (int c = 0; c < N_CH; c++) begin
      e_ready[c] = (m_mode == M_RUN) && (m_slot[c].size() == 0);
      if (m_slot[c].size() != 0) anyp = 1'b1;
    end
    for (int k = N_CH - 1; k >= 0; k--)
      if (m_slot[(m_ptr + k) % N_CH].size() != 0) e_grant = (m_ptr + k) % N_CH;
    e_go   = (m_mode == M_RUN || m_mode == M_DRAIN) && anyp && !bus.fifo_full;
    e_data = e_go ? m_slot[e_grant][0] : '0;
  endtask

  task automatic m_step();
    logic [N_CH-1:0] occ;
    int n;
    for (int c = 0; c < N_CH; c++) occ[c] = (m_slot[c].size() != 0);
    if (m_mode == M_CLEAR) begin
      for (int c = 0; c < N_CH; c++) m_slot[c].delete();
      m_ptr = 0; m_ovf = '0; m_drops = 0; m_ferr = 1'b0;
    end else begin
      n = 0;
      if (m_mode == M_RUN) begin
        for (int c = 0; c < N_CH; c++) begin
          if (bus.ch_valid[c]) begin
            if (occ[c]) begin m_ovf[c] = 1'b1; n++; end
            else m_slot[c].push_back(bus.ch_data[c*LENGTH +: LENGTH]);
          end
        end
      end
      if (e_go) begin
        void'(m_slot[e_grant].pop_front());
        m_ptr = (e_grant + 1) % N_CH;
      end
      m_drops = (m_drops + n > CNT_MAX) ? CNT_MAX : m_drops + n;
      if (bus.fifo_full_error) m_ferr = 1'b1;
    end
    if (bus.clear_req) m_mode = M_CLEAR;
    else case (m_mode)
      M_IDLE:  if (bus.enable)  m_mode = M_RUN;
      M_RUN:   if (!bus.enable) m_mode = M_DRAIN;
      M_DRAIN: if (occ == '0)   m_mode = M_IDLE;
      default: m_mode = bus.enable ? M_RUN : M_IDLE;
    endcase
  endtask

  // Called at a negedge with inputs already set; compares, clocks, returns at next negedge.
  task automatic cycle();
    #1;
    m_eval();
    obs_write = bus.fifo_write;  obs_data = bus.fifo_i_data; obs_clear = bus.fifo_clear;
    obs_busy  = bus.busy;        obs_ready = bus.ch_ready;   obs_ovf   = bus.overflow;
    obs_drop  = bus.drop_cnt;    obs_ferr  = bus.full_err;
    check("ch_ready",   obs_ready, e_ready);
    check("fifo_write", obs_write, e_go);
    check("fifo_data",  obs_data,  e_data);
    check("fifo_clear", obs_clear, m_mode == M_CLEAR);
    check("busy",       obs_busy,  m_mode != M_IDLE);
    check("overflow",   obs_ovf,   m_ovf);
    check("drop_cnt",   obs_drop,  CNT_W'(m_drops));
    check("full_err",   obs_ferr,  m_ferr);
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  function automatic logic [LENGTH-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[LENGTH-1:0];
  endfunction

  task automatic idle_inputs();
    bus.ch_valid = '0; bus.clear_req = 1'b0; bus.fifo_full = 1'b0; bus.fifo_full_error = 1'b0;
  endtask

  task automatic set_data(input int c, input logic [LENGTH-1:0] w);
    bus.ch_data[c*LENGTH +: LENGTH] = w;
  endtask

  initial begin
    logic [LENGTH-1:0] t2_exp [3];
    logic [LENGTH-1:0] w;
    int n_wr;
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0;
    bus.enable = 1'b0; bus.clear_req = 1'b0; bus.ch_valid = '1; bus.ch_data = '0;
    bus.fifo_full = 1'b0; bus.fifo_full_error = 1'b0;
    m_reset();

    // 1: reset with all valids high
    @(negedge clk); #1;
    check("t1_ready", bus.ch_ready, '0);
    check("t1_write", bus.fifo_write, 1'b0);
    check("t1_busy",  bus.busy, 1'b0);
    check("t1_drop",  bus.drop_cnt, '0);
    check("t1_data",  bus.fifo_i_data, '0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_inputs();
    cycle();

    // 2: three channels strobed together drain in order, pointer ends at 3
    bus.enable = 1'b1;
    cycle();
    t2_exp[0] = 68'hA; t2_exp[1] = 68'hB; t2_exp[2] = 68'hC;
    for (int c = 0; c < 3; c++) set_data(c, t2_exp[c]);
    bus.ch_valid = 4'b0111;
    cycle();
    bus.ch_valid = '0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t2_write", obs_write, 1'b1);
      check("t2_data",  obs_data,  t2_exp[k]);
    end
    for (int c = 0; c < N_CH; c++) set_data(c, LENGTH'(16 * c + 5));
    bus.ch_valid = 4'b1111;
    cycle();
    bus.ch_valid = '0;
    cycle();
    check("t2_ptr", obs_data, LENGTH'(16 * 3 + 5));

    // 3: every channel refilled as soon as ready, one write per clock
    for (int i = 0; i < 40; i++) begin
      m_eval();
      bus.ch_valid = e_ready;
      for (int c = 0; c < N_CH; c++) set_data(c, rand_word());
      cycle();
      check("t3_write", obs_write, 1'b1);
    end
    idle_inputs();
    repeat (6) cycle();

    // 4: full stalls ch1 while it is strobed three more times
    w = rand_word();
    set_data(1, w);
    bus.ch_valid = 4'b0010;
    cycle();
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.ch_valid = (i < 3) ? 4'b0010 : 4'b0000;
      set_data(1, rand_word());
      cycle();
      check("t4_nowrite", obs_write, 1'b0);
    end
    idle_inputs();
    cycle();
    check("t4_write", obs_write, 1'b1);
    check("t4_data",  obs_data, w);
    check("t4_ovf",   obs_ovf, 4'b0010);
    check("t4_drop",  obs_drop, 16'd3);

    // 5: disable with two held samples; drain writes both then goes idle
    bus.fifo_full = 1'b1;
    set_data(0, rand_word()); set_data(2, rand_word());
    bus.ch_valid = 4'b0101;
    cycle();
    bus.ch_valid = '0;
    bus.enable = 1'b0;
    cycle();
    bus.fifo_full = 1'b0;
    n_wr = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_wr += int'(obs_write);
    end
    check("t5_writes", n_wr, 2);
    check("t5_busy",   obs_busy, 1'b0);
    check("t5_ready",  obs_ready, '0);

    // 6: clear with three held samples and sticky status set
    bus.enable = 1'b1;
    cycle();
    bus.fifo_full = 1'b1; bus.fifo_full_error = 1'b1;
    for (int c = 0; c < N_CH; c++) set_data(c, rand_word());
    bus.ch_valid = 4'b0111;
    cycle();
    bus.fifo_full_error = 1'b0;
    bus.ch_valid = 4'b0001;
    cycle();
    check("t6_ferr_set", obs_ferr, 1'b1);
    bus.ch_valid = '0;
    bus.clear_req = 1'b1;
    cycle();
    bus.clear_req = 1'b0;
    cycle();
    check("t6_clear", obs_clear, 1'b1);
    check("t6_nowr",  obs_write, 1'b0);
    bus.fifo_full = 1'b0;
    cycle();
    check("t6_ovf",   obs_ovf, '0);
    check("t6_drop",  obs_drop, '0);
    check("t6_ferr",  obs_ferr, 1'b0);
    check("t6_ready", obs_ready, 4'b1111);
    check("t6_nopend", obs_write, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.enable          = ($urandom_range(0, 9) != 0);
      bus.clear_req       = ($urandom_range(0, 49) == 0);
      bus.fifo_full       = ($urandom_range(0, 9) < 3);
      bus.fifo_full_error = ($urandom_range(0, 49) == 0);
      bus.ch_valid        = N_CH'($urandom());
      for (int c = 0; c < N_CH; c++) set_data(c, rand_word());
      cycle();
    end

    // Reset asserted mid-operation
    idle_inputs();
    bus.enable = 1'b1; bus.fifo_full = 1'b1; bus.ch_valid = '1;
    repeat (3) cycle();
    reset_n = 1'b0;
    #1;
    m_reset();
    check("rst_busy",  bus.busy, 1'b0);
    check("rst_ready", bus.ch_ready, '0);
    check("rst_write", bus.fifo_write, 1'b0);
    check("rst_data",  bus.fifo_i_data, '0);
    check("rst_ovf",   bus.overflow, '0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_inputs();
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
